// File: rtl/nld_pkg.sv
// Shared constants and pipeline stage types for the NLD output stage.
// Q2.14 gain format, register indices and 16-bit sample saturation limits.
package nld_pkg;

  localparam int GAIN_FRAC_BITS = 14;
  localparam logic signed [15:0] GAIN_UNITY = 16'sh4000;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_GAIN  = 2'd1;
  localparam logic [1:0] REG_RAMP  = 2'd2;
  localparam logic [1:0] REG_METER = 2'd3;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  typedef struct packed {
    logic signed [31:0] prod;
    logic               last;
  } s1_t;

  typedef struct packed {
    logic signed [15:0] dat;
    logic               last;
  } s2_t;

endpackage

// File: rtl/nld_gain_ramp.sv
// Zipper-free gain ramp: cur_gain steps toward target by at most step per adv strobe.
// Latency: new cur_gain visible the cycle after adv; no backpressure (holds when adv=0).
// step=0 means jump straight to target.
module nld_gain_ramp (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               adv,
  input  logic signed [15:0] target,
  input  logic [15:0]        step,
  output logic signed [15:0] cur_gain
);
  import nld_pkg::*;

  logic signed [17:0] cur_ext, tgt_ext, step_ext, diff, nxt;
  logic [17:0]        mag;
  logic               unused_nxt;

  assign cur_ext  = {{2{cur_gain[15]}}, cur_gain};
  assign tgt_ext  = {{2{target[15]}}, target};
  assign step_ext = $signed({2'b00, step});

  always_comb begin
    diff = tgt_ext - cur_ext;
    mag  = diff[17] ? -diff : diff;
    if (step == '0 || mag <= {2'b00, step})
      nxt = tgt_ext;
    else if (diff[17])
      nxt = cur_ext - step_ext;
    else
      nxt = cur_ext + step_ext;
  end

  // nxt always lies between cur_gain and target, so the top bits carry no information
  assign unused_nxt = &{1'b0, nxt[17:16]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      cur_gain <= GAIN_UNITY;
    else if (adv)
      cur_gain <= nxt[15:0];
  end

endmodule

// File: rtl/axis_nld_output_stage.sv
// Ramped makeup gain + saturation on the NLD output stream, AXI-Lite control; OUTSTAGE_PEAK_METER_EN adds the peak/clip meter.
// Latency: 2 cycles input to output at full throughput (1 sample/cycle).
// Backpressure: two-stage valid/ready pipeline, each stage advances when empty or when the next accepts.
module axis_nld_output_stage #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_AXIS_DATA_WIDTH  = 16,
  parameter int GAIN_FRAC_BITS     = nld_pkg::GAIN_FRAC_BITS
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);
  import nld_pkg::*;

  localparam logic signed [31:0] RND_HALF = 32'sd1 <<< (GAIN_FRAC_BITS - 1);

  logic                          wr_hs, en_q, s2_adv, sat_hit, unused_addr;
  logic [1:0]                    wr_sel, rd_sel;
  logic signed [15:0]            gain_q, cur_gain, eff_target, sat_y;
  logic [15:0]                   ramp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic signed [31:0]            x_ext, g_ext, rnd, shifted;
  s1_t                           s1_q;
  s2_t                           s2_q;
  logic                          s1_vld, s2_vld;

  assign wr_sel        = s_axi_awaddr[3:2];
  assign rd_sel        = s_axi_araddr[3:2];
  assign wr_hs         = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_arready = s_axi_arvalid && !s_axi_rvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign unused_addr   = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:16]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q         <= 1'b0;
      gain_q       <= GAIN_UNITY;
      ramp_q       <= '0;
      s_axi_bvalid <= 1'b0;
    end else if (wr_hs) begin
      case (wr_sel)
        REG_CTRL: en_q   <= s_axi_wdata[0];
        REG_GAIN: gain_q <= s_axi_wdata[15:0];
        REG_RAMP: ramp_q <= s_axi_wdata[15:0];
        default: ;
      endcase
      s_axi_bvalid <= 1'b1;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

`ifdef OUTSTAGE_PEAK_METER_EN
  logic        peak_clear, clip_q;
  logic [15:0] peak_q, y_mag;

  assign peak_clear = wr_hs && (wr_sel == REG_CTRL) && s_axi_wdata[1];

  // |-32768| is clamped so the meter stays a 15-bit magnitude
  always_comb begin
    if (m_axis_tdata == 16'h8000)
      y_mag = 16'h7FFF;
    else if (m_axis_tdata[15])
      y_mag = -m_axis_tdata;
    else
      y_mag = m_axis_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      peak_q <= '0;
      clip_q <= 1'b0;
    end else if (peak_clear) begin
      peak_q <= '0;
      clip_q <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && y_mag > peak_q)
        peak_q <= y_mag;
      if (s2_adv && s1_vld && sat_hit)
        clip_q <= 1'b1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_hit;
`endif

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      REG_CTRL: rd_word = {31'b0, en_q};
      REG_GAIN: rd_word = {16'b0, gain_q};
      REG_RAMP: rd_word = {16'b0, ramp_q};
`ifdef OUTSTAGE_PEAK_METER_EN
      REG_METER: rd_word = {15'b0, clip_q, peak_q};
`endif
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else if (s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // Disabling falls back to unity through the same ramp, so enable toggles are click-free
  assign eff_target = en_q ? gain_q : GAIN_UNITY;

  nld_gain_ramp u_ramp (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .adv      (s_axis_tvalid && s_axis_tready),
    .target   (eff_target),
    .step     (ramp_q),
    .cur_gain (cur_gain)
  );

  assign s2_adv        = !s2_vld || m_axis_tready;
  assign s_axis_tready = !s1_vld || s2_adv;
  assign x_ext         = $signed({{16{s_axis_tdata[15]}}, s_axis_tdata});
  assign g_ext         = $signed({{16{cur_gain[15]}}, cur_gain});

  always_comb begin
    rnd     = $signed(s1_q.prod) + RND_HALF;
    shifted = rnd >>> GAIN_FRAC_BITS;
    sat_hit = 1'b0;
    sat_y   = shifted[15:0];
    if (shifted > SAMPLE_MAX) begin
      sat_y   = 16'(SAMPLE_MAX);
      sat_hit = 1'b1;
    end else if (shifted < SAMPLE_MIN) begin
      sat_y   = 16'(SAMPLE_MIN);
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
      s2_vld <= 1'b0;
      s2_q   <= '0;
    end else begin
      if (s_axis_tready) begin
        s1_vld <= s_axis_tvalid;
        if (s_axis_tvalid)
          s1_q <= '{prod: x_ext * g_ext, last: s_axis_tlast};
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld)
          s2_q <= '{dat: sat_y, last: s1_q.last};
      end
    end
  end

  assign m_axis_tdata  = s2_q.dat;
  assign m_axis_tlast  = s2_q.last;
  assign m_axis_tvalid = s2_vld;

endmodule

// File: tb/tb_axis_nld_output_stage.sv
// Bench for axis_nld_output_stage: directed vectors, queue-based reference model checked every output beat.
// Meter expectations follow OUTSTAGE_PEAK_METER_EN (reads of addr 3 are zero without it).
module tb_axis_nld_output_stage;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [15:0] s_axis_tdata, m_axis_tdata;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;

  always #5 aclk = ~aclk;

  axis_nld_output_stage dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  typedef struct { int y; bit last; bit sat; int cyc; } exp_t;

  exp_t        expq[$];
  int          got_y[$], got_lat[$], got_last[$];
  int          m_cur, m_gain, m_ramp, m_peak;
  bit          m_en, m_clip;
  int          n_chk = 0, n_pass = 0, cyc = 0;
  bit          held, bp_done;
  logic [15:0] held_dat;
  logic        held_last;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    m_cur = 16384; m_gain = 16384; m_ramp = 0; m_en = 0; m_peak = 0; m_clip = 0;
  endfunction

  // Expected output for one accepted input, then the gain ramp rule for the next beat
  function automatic void model_in(input logic [15:0] x, input logic last);
    exp_t   e;
    longint p;
    int     tgt, d, ad;
    p = (longint'($signed(x)) * m_cur + 8192) >>> 14;
    e.sat = 0;
    if (p > 32767) begin p = 32767; e.sat = 1; end
    else if (p < -32768) begin p = -32768; e.sat = 1; end
    e.y = int'(p); e.last = last; e.cyc = cyc;
    expq.push_back(e);
    tgt = m_en ? m_gain : 16384;
    d   = tgt - m_cur;
    ad  = (d < 0) ? -d : d;
    if (m_ramp == 0 || ad <= m_ramp) m_cur = tgt;
    else m_cur = m_cur + ((d > 0) ? m_ramp : -m_ramp);
  endfunction

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0: return {31'b0, m_en};
      1: return {16'b0, 16'(m_gain)};
      2: return {16'b0, 16'(m_ramp)};
`ifdef OUTSTAGE_PEAK_METER_EN
      default: return {15'b0, m_clip, 16'(m_peak)};
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  // Compare process: values seen at negedge are the ones the next posedge acts on
  always @(negedge aclk) begin
    exp_t e;
    int   mag;
    cyc++;
    if (!aresetn) begin
      expq.delete();
      model_reset();
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", m_axis_tdata, held_dat);
        chk("hold_last", m_axis_tlast, held_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("out_data", int'($signed(m_axis_tdata)), e.y);
          chk("out_last", m_axis_tlast, e.last);
          got_y.push_back(int'($signed(m_axis_tdata)));
          got_lat.push_back(cyc - e.cyc);
          got_last.push_back(int'(m_axis_tlast));
          mag = (e.y < 0) ? -e.y : e.y;
          if (mag > 32767) mag = 32767;
          if (mag > m_peak) m_peak = mag;
          if (e.sat) m_clip = 1;
        end
      end
      held      = m_axis_tvalid && !m_axis_tready;
      held_dat  = m_axis_tdata;
      held_last = m_axis_tlast;
      if (s_axis_tvalid && s_axis_tready) model_in(s_axis_tdata, s_axis_tlast);
      if (s_axi_awvalid && s_axi_wvalid && s_axi_awready) begin
        case (s_axi_awaddr[3:2])
          2'd0: begin
            m_en = s_axi_wdata[0];
            if (s_axi_wdata[1]) begin m_peak = 0; m_clip = 0; end
          end
          2'd1: m_gain = int'($signed(s_axi_wdata[15:0]));
          2'd2: m_ramp = int'(s_axi_wdata[15:0]);
          default: ;
        endcase
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge
  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    int t = 0;
    s_axi_awaddr = a; s_axi_wdata = v; s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(negedge aclk);
    while (!s_axi_awready && t < 50) begin @(negedge aclk); t++; end
    chk("wr_handshake_in_time", t < 50, 1);
    @(posedge aclk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    t = 0;
    @(negedge aclk);
    while (!s_axi_bvalid && t < 50) begin @(negedge aclk); t++; end
    chk("wr_bresp", {t < 50, s_axi_bresp}, 3'b100);
    @(posedge aclk); #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    int t = 0;
    s_axi_araddr = a; s_axi_arvalid = 1;
    @(negedge aclk);
    while (!s_axi_arready && t < 50) begin @(negedge aclk); t++; end
    @(posedge aclk); #1;
    s_axi_arvalid = 0;
    @(negedge aclk);
    while (!s_axi_rvalid && t < 100) begin @(negedge aclk); t++; end
    chk("rd_in_time", {t < 100, s_axi_rresp}, 3'b100);
    d = s_axi_rdata;
    @(posedge aclk); #1;
  endtask

  task automatic send(input logic [15:0] x, input logic last);
    int t = 0;
    s_axis_tdata = x; s_axis_tlast = last; s_axis_tvalid = 1;
    @(negedge aclk);
    while (!s_axis_tready && t < 200) begin @(negedge aclk); t++; end
    chk("send_in_time", t < 200, 1);
    @(posedge aclk); #1;
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge aclk);
    while ((expq.size() != 0 || m_axis_tvalid) && t < 300) begin @(negedge aclk); t++; end
    chk("drain_in_time", t < 300, 1);
    @(posedge aclk); #1;
  endtask

  task automatic clear_got();
    got_y.delete(); got_lat.delete(); got_last.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          ramp_exp[6] = '{16384, 12288, 8192, 4096, 0, 0};
    int          nlast;

    aresetn = 0;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wvalid = 0; s_axi_bready = 1;
    s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 1;
    s_axis_tdata = 0; s_axis_tlast = 0; s_axis_tvalid = 0; m_axis_tready = 1;
    @(posedge aclk); #1;

    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk); #1;

    rd(4'h0, d); chk("rst_reg_ctrl", d, 32'h0);
    rd(4'h4, d); chk("rst_reg_gain", d, 32'h4000);
    rd(4'h8, d); chk("rst_reg_ramp", d, 32'h0);
    rd(4'hC, d); chk("rst_reg_meter", d, 32'h0);

    // Unity path and 2-cycle latency
    clear_got();
    send(16'd1000, 1'b1);
    drain();
    chk("lat_count", got_y.size(), 1);
    if (got_y.size() == 1) begin
      chk("lat_y", got_y[0], 1000);
      chk("lat_cycles", got_lat[0], 2);
    end

    // Gain -2.0 saturates both ways; the priming beat still runs at the old gain
    wr(4'h4, 32'h8000); wr(4'h8, 32'h0); wr(4'h0, 32'h1);
    rd(4'h4, d); chk("gain_readback", d, 32'h8000);
    clear_got();
    send(16'd0, 1'b0);
    send(16'd20000, 1'b0);
    send(16'(-20000), 1'b1);
    drain();
    chk("sat_count", got_y.size(), 3);
    if (got_y.size() == 3) begin
      chk("sat_neg", got_y[1], -32768);
      chk("sat_pos", got_y[2], 32767);
    end
    rd(4'hC, d); chk("sat_meter_model", d, exp_reg(3));
`ifdef OUTSTAGE_PEAK_METER_EN
    chk("sat_clip_bit", d[16], 1);
`endif

    // Ramp 1.0 -> 0.0 in steps of 0.25
    wr(4'h0, 32'h0); wr(4'h8, 32'h0);
    send(16'd0, 1'b0);
    drain();
    wr(4'h4, 32'h0); wr(4'h8, 32'd4096); wr(4'h0, 32'h1);
    clear_got();
    for (int i = 0; i < 6; i++) send(16'd16384, i == 5);
    drain();
    chk("ramp_count", got_y.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_y.size()) chk("ramp_y", got_y[i], ramp_exp[i]);

    // Random output stalls over a ramped, partly saturating stream
    wr(4'h4, 32'h5000); wr(4'h8, 32'd1000); wr(4'h0, 32'h1);
    clear_got();
    bp_done = 0;
    fork
      begin
        for (int i = 0; i < 64; i++) send(16'(i * 7919 + 123), i == 63);
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge aclk); #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1;
    drain();
    chk("bp_count", got_y.size(), 64);
    nlast = 0;
    foreach (got_last[i]) nlast += got_last[i];
    chk("bp_last_count", nlast, 1);
    if (got_last.size() == 64) chk("bp_last_pos", got_last[63], 1);

    // Peak metering, then clear coinciding with an output beat
    wr(4'h4, 32'h4000); wr(4'h8, 32'h0); wr(4'h0, 32'h3);
    send(16'd0, 1'b0);
    send(16'h8000, 1'b0);
    send(16'd5000, 1'b0);
    drain();
    rd(4'hC, d); chk("peak_meter_model", d, exp_reg(3));
`ifdef OUTSTAGE_PEAK_METER_EN
    chk("peak_meter_lit", d, 32'h7FFF);
`endif
    clear_got();
    s_axis_tdata = 16'd100; s_axis_tlast = 0; s_axis_tvalid = 1;
    @(posedge aclk); #1;
    s_axis_tvalid = 0;
    @(posedge aclk); #1;
    chk("clr_beat_ready", m_axis_tvalid, 1);
    s_axi_awaddr = 4'h0; s_axi_wdata = 32'h3; s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge aclk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(posedge aclk); #1;
    drain();
    if (got_y.size() == 1) chk("clr_beat_y", got_y[0], 100);
    rd(4'hC, d); chk("clr_meter_model", d, exp_reg(3));
    chk("clr_meter_lit", d, 32'h0);
    send(16'd200, 1'b1);
    drain();
    rd(4'hC, d); chk("post_clr_meter_model", d, exp_reg(3));
`ifdef OUTSTAGE_PEAK_METER_EN
    chk("post_clr_meter_lit", d, 32'd200);
`endif

    // Reset with two beats in flight
    wr(4'h4, 32'h2000); wr(4'h0, 32'h1);
    send(16'd0, 1'b0);
    drain();
    m_axis_tready = 0;
    send(16'd4000, 1'b0);
    send(16'd4000, 1'b0);
    chk("mid_vld_before", m_axis_tvalid, 1);
    aresetn = 0;
    #1;
    chk("mid_vld_drop", m_axis_tvalid, 0);
    @(posedge aclk); #1;
    aresetn = 1;
    m_axis_tready = 1;
    clear_got();
    @(posedge aclk); #1;
    send(16'd777, 1'b1);
    drain();
    chk("mid_post_count", got_y.size(), 1);
    if (got_y.size() == 1) chk("mid_post_y", got_y[0], 777);
    rd(4'h0, d); chk("mid_ctrl_reset", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
